// File: rtl/module_bcd_binario.sv
// Sequential BCD-to-binary converter: Horner accumulation acc = acc*10 + digit, one digit per clock.
// Latency 4 clocks from acceptance to the listo pulse, or 1 clock when a digit is invalid. inicio is ignored while busy.
module module_bcd_binario #(
    parameter int ANCHO = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inicio,
    input  logic [3:0]       millares_input,
    input  logic [3:0]       centenas_input,
    input  logic [3:0]       decenas_input,
    input  logic [3:0]       unidades_input,
    output logic [ANCHO-1:0] numero_output,
    output logic             listo,
    output logic             ocupado,
    output logic             error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } estado_t;

    estado_t           r_estado;
    estado_t           w_estado_sig;
    logic [3:0][3:0]   r_dig;
    logic [ANCHO-1:0]  r_acc;
    logic [1:0]        r_idx;
    logic [ANCHO-1:0]  w_acc_sig;
    logic [3:0]        w_dig_act;
    logic              w_invalido;

    always_comb begin
        w_invalido = (millares_input > 4'd9) || (centenas_input > 4'd9) ||
                     (decenas_input  > 4'd9) || (unidades_input > 4'd9);
        w_dig_act  = r_dig[r_idx];
        // acc*10 as two shifts and an add keeps a multiplier out of the netlist
        w_acc_sig  = (r_acc << 3) + (r_acc << 1) + {{(ANCHO-4){1'b0}}, w_dig_act};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_estado <= IDLE;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            IDLE: begin
                if (inicio) begin
                    w_estado_sig = w_invalido ? DONE : CONV;
                end
            end
            CONV: begin
                if (r_idx == 2'd0) begin
                    w_estado_sig = DONE;
                end
            end
            DONE:    w_estado_sig = IDLE;
            default: w_estado_sig = IDLE;
        endcase
    end

    always_comb begin
        ocupado = (r_estado != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dig         <= '0;
            r_acc         <= '0;
            r_idx         <= 2'd0;
            numero_output <= '0;
            listo         <= 1'b0;
            error         <= 1'b0;
        end else begin
            listo <= 1'b0;
            case (r_estado)
                IDLE: begin
                    if (inicio) begin
                        r_dig <= {millares_input, centenas_input, decenas_input, unidades_input};
                        error <= w_invalido;
                        if (w_invalido) begin
                            numero_output <= '0;
                            listo         <= 1'b1;
                        end else begin
                            r_acc <= '0;
                            r_idx <= 2'd3;
                        end
                    end
                end
                CONV: begin
                    r_acc <= w_acc_sig;
                    r_idx <= r_idx - 2'd1;
                    if (r_idx == 2'd0) begin
                        numero_output <= w_acc_sig;
                        listo         <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_module_bcd_binario.sv
// Directed bench for module_bcd_binario: vector table plus hand-written multi-cycle sequences.
module tb_module_bcd_binario;

    localparam int ANCHO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             inicio = 1'b0;
    logic [3:0]       millares_input = '0;
    logic [3:0]       centenas_input = '0;
    logic [3:0]       decenas_input = '0;
    logic [3:0]       unidades_input = '0;
    logic [ANCHO-1:0] numero_output;
    logic             listo;
    logic             ocupado;
    logic             error;

    int total = 0;
    int bad   = 0;

    module_bcd_binario #(.ANCHO(ANCHO)) dut (
        .clk            (clk),
        .rst            (rst),
        .inicio         (inicio),
        .millares_input (millares_input),
        .centenas_input (centenas_input),
        .decenas_input  (decenas_input),
        .unidades_input (unidades_input),
        .numero_output  (numero_output),
        .listo          (listo),
        .ocupado        (ocupado),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  m, c, d, u;
        logic [15:0] exp_num;
        logic        exp_err;
        int          exp_wait;   // extra edges after the accepting edge until listo is visible
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] m, input logic [3:0] c,
                              input logic [3:0] d, input logic [3:0] u);
        millares_input = m;
        centenas_input = c;
        decenas_input  = d;
        unidades_input = u;
    endtask

    // Issue a one-cycle request from IDLE and check latency, result, pulse width and return to IDLE.
    task automatic do_req(input string name, input vec_t v);
        logic [15:0] prev;
        int w;
        prev = numero_output;
        @(negedge clk);
        set_digits(v.m, v.c, v.d, v.u);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        check({name, ".ocupado_acc"}, 32'(ocupado), 32'd1);
        if (v.exp_wait > 0) check({name, ".num_hold"}, 32'(numero_output), 32'(prev));
        w = 0;
        while (!listo && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({name, ".latency"}, w, v.exp_wait);
        check({name, ".num"}, 32'(numero_output), 32'(v.exp_num));
        check({name, ".err"}, 32'(error), 32'(v.exp_err));
        @(negedge clk);
        check({name, ".listo_1cyc"}, 32'(listo), 32'd0);
        check({name, ".idle"}, 32'(ocupado), 32'd0);
    endtask

    vec_t tbl[7];
    int   pulses[$];
    int   w;

    initial begin
        tbl[0] = '{4'd1, 4'd2, 4'd3, 4'd4, 16'h04D2, 1'b0, 4};
        tbl[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 16'h270F, 1'b0, 4};
        tbl[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b0, 4};
        tbl[3] = '{4'd1, 4'd2, 4'hA, 4'd4, 16'h0000, 1'b1, 0};
        tbl[4] = '{4'd0, 4'd0, 4'd5, 4'd6, 16'h0038, 1'b0, 4};
        tbl[5] = '{4'hF, 4'd0, 4'd0, 4'd0, 16'h0000, 1'b1, 0};
        tbl[6] = '{4'd0, 4'd0, 4'd0, 4'd9, 16'h0009, 1'b0, 4};

        repeat (3) @(negedge clk);
        check("rst.num", 32'(numero_output), 32'd0);
        check("rst.listo", 32'(listo), 32'd0);
        check("rst.err", 32'(error), 32'd0);
        check("rst.ocupado", 32'(ocupado), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_req($sformatf("vec%0d", i), tbl[i]);
        end

        // Inputs changed and inicio re-pulsed while converting: both must be ignored.
        @(negedge clk);
        set_digits(4'd5, 4'd6, 4'd7, 4'd8);
        inicio = 1'b1;
        @(negedge clk);
        set_digits(4'd1, 4'd1, 4'd1, 4'd1);
        @(negedge clk);
        inicio = 1'b0;
        w = 1;
        while (!listo && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("busy.latency", w, 4);
        check("busy.num", 32'(numero_output), 32'h162E);
        repeat (4) begin
            @(negedge clk);
            check("busy.no_extra_listo", 32'(listo), 32'd0);
        end
        check("busy.idle", 32'(ocupado), 32'd0);

        // inicio held high: one result every 6 cycles.
        set_digits(4'd0, 4'd0, 4'd1, 4'd0);
        inicio = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (listo) begin
                pulses.push_back(k);
                check("hold.num", 32'(numero_output), 32'h000A);
            end
        end
        inicio = 1'b0;
        check("hold.count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("hold.first", pulses[0], 5);
            check("hold.period1", pulses[1] - pulses[0], 6);
            check("hold.period2", pulses[2] - pulses[1], 6);
        end
        repeat (8) @(negedge clk);
        check("hold.drain", 32'(ocupado), 32'd0);

        // Reset in the middle of a conversion discards it.
        set_digits(4'd3, 4'd3, 4'd3, 4'd3);
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst.num", 32'(numero_output), 32'd0);
        check("midrst.listo", 32'(listo), 32'd0);
        check("midrst.err", 32'(error), 32'd0);
        check("midrst.ocupado", 32'(ocupado), 32'd0);
        repeat (6) begin
            @(negedge clk);
            check("midrst.no_listo", 32'(listo), 32'd0);
        end
        do_req("after_rst", '{4'd0, 4'd1, 4'd0, 4'd0, 16'h0064, 1'b0, 4});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
